onehot_phase_gen: RTL and testbench

- Upstream generator of rotating one-hot phase signals and matching single-cycle phase strobes, all derived from clk.
- Downstream capture stages use phase_rise_stb[k] as a clock enable in the clk domain. Fabric data is never used as a clock.
- Adds a programmable hold time per phase, a synchronous restart, and self-correction of illegal ring states.

---
 rtl/onehot_phase_pkg.sv | 34 +++
 rtl/onehot_phase_gen_counter.sv | 39 +++
 rtl/onehot_phase_gen.sv | 134 +++++++++++++
 tb/tb_onehot_phase_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_phase_pkg.sv
// Shared types and helpers for the one-hot phase generator.
//   state_t     : controller state (IDLE, RUN)
//   onehot_ok   : 1 when exactly one bit of the (zero-extended) vector is set
//   onehot2idx  : binary index of the set bit of a one-hot vector
// Helpers take a fixed MAX_PHASES-wide vector; callers zero-extend.
package onehot_phase_pkg;

  localparam int MAX_PHASES = 64;
  localparam int MAX_IDX_W  = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic onehot_ok(input logic [MAX_PHASES-1:0] vec);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < MAX_PHASES; i++) begin
      ones += 32'(vec[i]);
    end
    return (ones == 1);
  endfunction

  function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_PHASES-1:0] vec);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PHASES; i++) begin
      if (vec[i]) idx = MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_phase_gen_counter.sv
// Per-phase hold counter.
//   clk, rst : clock, asynchronous active-high reset
//   load     : counter <= 0 and latch div into div_l (start, restart, phase boundary)
//   clear    : counter <= 0, div_l kept (idle, illegal-state recovery)
//   div      : hold length minus 1
//   terminal : counter == div_l, i.e. last cycle of the current phase
// With neither load nor clear the counter increments; the controller loads it on
// every terminal cycle, so it never runs past div_l.
module phase_hold_counter #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             terminal
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_l_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      div_l_q <= '0;
    end else if (load) begin
      cnt_q   <= '0;
      div_l_q <= div;
    end else if (clear) begin
      cnt_q   <= '0;
    end else begin
      cnt_q   <= cnt_q + DIV_W'(1);
    end
  end

  assign terminal = (cnt_q == div_l_q);

endmodule

// File: rtl/onehot_phase_gen.sv
// Rotating one-hot phase generator with per-phase hold time.
//   clk, rst       : sole clock, asynchronous active-high reset
//   en             : run enable; low returns the ring to idle (all zero)
//   div            : phase hold length minus 1 (sampled at start/restart/boundary)
//   sync_start     : restart the ring at phase 0
//   phase_out      : one-hot active phase, zero when idle
//   phase_idx      : binary index of the active phase
//   phase_rise_stb : pulse on the first cycle of each phase
//   wrap_stb       : pulse when phase NUM_PHASES-1 hands over to phase 0
//   err_recover    : pulse when a non-one-hot ring was forced back to phase 0
// All outputs are registers, so strobes line up with the first phase cycle.
// Controller state is visible as state_q.
module onehot_phase_gen
  import onehot_phase_pkg::*;
#(
  parameter int  NUM_PHASES = 2,
  parameter int  DIV_W      = 8,
  localparam int IDX_W      = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DIV_W-1:0]      div,
  input  logic                  sync_start,
  output logic [NUM_PHASES-1:0] phase_out,
  output logic [IDX_W-1:0]      phase_idx,
  output logic [NUM_PHASES-1:0] phase_rise_stb,
  output logic                  wrap_stb,
  output logic                  err_recover
);

  if (NUM_PHASES < 2 || NUM_PHASES > MAX_PHASES) begin : g_bad_num_phases
    $error("onehot_phase_gen: NUM_PHASES must be in 2..64");
  end

  localparam logic [NUM_PHASES-1:0] BIT0 = NUM_PHASES'(1);

  state_t                state_q, state_d;
  logic [NUM_PHASES-1:0] ring_q, ring_d;
  logic [NUM_PHASES-1:0] ring_cur;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_PHASES-1:0] rise_q, rise_d;
  logic                  wrap_q, wrap_d;
  logic                  err_q, err_d;
  logic                  cnt_load, cnt_clear, cnt_terminal;

  // Current ring value as seen by the next-state logic and the outputs.
  assign ring_cur = ring_q;

  phase_hold_counter #(.DIV_W(DIV_W)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .clear    (cnt_clear),
    .div      (div),
    .terminal (cnt_terminal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ring_q  <= '0;
      idx_q   <= '0;
      rise_q  <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      idx_q   <= idx_d;
      rise_q  <= rise_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  // Priority inside RUN: en low > sync_start > illegal ring > phase advance.
  always_comb begin
    state_d   = state_q;
    ring_d    = ring_cur;
    rise_d    = '0;
    wrap_d    = 1'b0;
    err_d     = 1'b0;
    cnt_load  = 1'b0;
    cnt_clear = 1'b0;
    case (state_q)
      IDLE: begin
        ring_d    = '0;
        cnt_clear = 1'b1;
        if (en) begin
          state_d  = RUN;
          ring_d   = BIT0;
          rise_d   = BIT0;
          cnt_load = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_d   = IDLE;
          ring_d    = '0;
          cnt_clear = 1'b1;
        end else if (sync_start) begin
          ring_d   = BIT0;
          rise_d   = BIT0;
          cnt_load = 1'b1;
        end else if (!onehot_ok(MAX_PHASES'(ring_cur))) begin
          // Recovery keeps the latched hold length; only the counter restarts.
          ring_d    = BIT0;
          rise_d    = BIT0;
          err_d     = 1'b1;
          cnt_clear = 1'b1;
        end else if (cnt_terminal) begin
          ring_d   = {ring_cur[NUM_PHASES-2:0], ring_cur[NUM_PHASES-1]};
          rise_d   = {ring_cur[NUM_PHASES-2:0], ring_cur[NUM_PHASES-1]};
          wrap_d   = ring_cur[NUM_PHASES-1];
          cnt_load = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        ring_d    = '0;
        cnt_clear = 1'b1;
      end
    endcase
    idx_d = IDX_W'(onehot2idx(MAX_PHASES'(ring_d)));
  end

  assign phase_out      = ring_cur;
  assign phase_idx      = idx_q;
  assign phase_rise_stb = rise_q;
  assign wrap_stb       = wrap_q;
  assign err_recover    = err_q;

endmodule

// File: tb/tb_onehot_phase_gen.sv
module tb_onehot_phase_gen;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             sync_start = 1'b0;
  logic [DIV_W-1:0] div = '0;

  logic [1:0] po2, rs2;
  logic [0:0] idx2;
  logic       wr2, er2;
  logic [3:0] po4, rs4;
  logic [1:0] idx4;
  logic       wr4, er4;

  int vectors = 0;
  int miscompares = 0;

  // Reference model per instance (0: 2 phases, 1: 4 phases)
  int nph[2] = '{2, 4};
  bit m_run[2];
  int m_ph[2], m_rem[2], m_hold[2];
  bit m_rise[2], m_wrap[2], m_err[2];

  always #5 clk = ~clk;

  onehot_phase_gen #(.NUM_PHASES(2), .DIV_W(DIV_W)) u2 (
    .clk(clk), .rst(rst), .en(en), .div(div), .sync_start(sync_start),
    .phase_out(po2), .phase_idx(idx2), .phase_rise_stb(rs2),
    .wrap_stb(wr2), .err_recover(er2)
  );

  onehot_phase_gen #(.NUM_PHASES(4), .DIV_W(DIV_W)) u4 (
    .clk(clk), .rst(rst), .en(en), .div(div), .sync_start(sync_start),
    .phase_out(po4), .phase_idx(idx4), .phase_rise_stb(rs4),
    .wrap_stb(wr4), .err_recover(er4)
  );

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[inst%0d] t=%0t got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_ph[i] = 0; m_rem[i] = 0; m_hold[i] = 0;
      m_rise[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
    end
  endtask

  // One clock edge of the spec-level behaviour: phase index plus cycles left in the phase.
  task automatic model_step(input bit illegal);
    for (int i = 0; i < 2; i++) begin
      m_rise[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
      if (!m_run[i]) begin
        if (en) begin
          m_run[i] = 1; m_ph[i] = 0; m_hold[i] = int'(div); m_rem[i] = int'(div); m_rise[i] = 1;
        end
      end else if (!en) begin
        m_run[i] = 0; m_ph[i] = 0;
      end else if (sync_start) begin
        m_ph[i] = 0; m_hold[i] = int'(div); m_rem[i] = int'(div); m_rise[i] = 1;
      end else if (illegal) begin
        m_ph[i] = 0; m_rem[i] = m_hold[i]; m_rise[i] = 1; m_err[i] = 1;
      end else if (m_rem[i] == 0) begin
        m_ph[i] = (m_ph[i] + 1) % nph[i];
        m_hold[i] = int'(div); m_rem[i] = int'(div);
        m_rise[i] = 1; m_wrap[i] = (m_ph[i] == 0);
      end else begin
        m_rem[i]--;
      end
    end
  endtask

  function automatic logic [31:0] exp_out(input int i);
    return m_run[i] ? (32'd1 << m_ph[i]) : 32'd0;
  endfunction

  task automatic compare();
    check("phase_out", 0, 32'(po2), exp_out(0));
    check("phase_out", 1, 32'(po4), exp_out(1));
    check("phase_idx", 0, 32'(idx2), m_run[0] ? 32'(m_ph[0]) : 32'd0);
    check("phase_idx", 1, 32'(idx4), m_run[1] ? 32'(m_ph[1]) : 32'd0);
    check("rise_stb", 0, 32'(rs2), m_rise[0] ? exp_out(0) : 32'd0);
    check("rise_stb", 1, 32'(rs4), m_rise[1] ? exp_out(1) : 32'd0);
    check("wrap_stb", 0, 32'(wr2), 32'(m_wrap[0]));
    check("wrap_stb", 1, 32'(wr4), 32'(m_wrap[1]));
    check("err_recover", 0, 32'(er2), 32'(m_err[0]));
    check("err_recover", 1, 32'(er4), 32'(m_err[1]));
  endtask

  // Called at a negedge; returns at the following negedge after comparing.
  task automatic cycle();
    @(posedge clk);
    model_step(1'b0);
    @(negedge clk);
    compare();
  endtask

  // Overwrite both rings with non-one-hot values for the next edge only.
  task automatic cycle_forced(input logic [1:0] f2, input logic [3:0] f4);
    force u2.ring_cur = f2;
    force u4.ring_cur = f4;
    @(posedge clk);
    model_step(1'b1);
    #1;
    release u2.ring_cur;
    release u4.ring_cur;
    @(negedge clk);
    compare();
  endtask

  // Normal edge, then reset asserted between edges; released at the next negedge.
  task automatic async_reset();
    @(posedge clk);
    model_step(1'b0);
    #3 rst = 1'b1;
    #1;
    model_reset();
    compare();
    check("async_rst_phase", 0, 32'(po2), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    compare();
  endtask

  initial begin
    int lit1[7] = '{1, 2, 1, 2, 1, 2, 1};
    int litw[7] = '{0, 0, 1, 0, 1, 0, 1};
    int lit2[6] = '{1, 1, 1, 2, 2, 1};
    logic [3:0] f4;
    int r;

    // Reset state, before any clock edge
    model_reset();
    #2;
    compare();
    @(negedge clk);
    rst = 1'b0;
    cycle();
    cycle();

    // 1: two phases, div=0, rotate every cycle; wrap on cycles 3,5,7
    en = 1'b1; div = 8'd0;
    for (int k = 0; k < 7; k++) begin
      cycle();
      check("t1_phase", 0, 32'(po2), 32'(lit1[k]));
      check("t1_rise", 0, 32'(rs2), 32'(lit1[k]));
      check("t1_wrap", 0, 32'(wr2), 32'(litw[k]));
    end

    // 2: div=3, changed to 1 during phase 0
    en = 1'b0; cycle();
    en = 1'b1; div = 8'd3; cycle();
    check("t2_phase", 0, 32'(po2), 32'd1);
    div = 8'd1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("t2_phase", 0, 32'(po2), 32'(lit2[k]));
    end

    // 3: sync_start in phase 1, counter 1
    en = 1'b0; cycle();
    en = 1'b1; div = 8'd3;
    for (int k = 0; k < 6; k++) cycle();
    check("t3_pre_phase", 0, 32'(po2), 32'd2);
    sync_start = 1'b1; cycle();
    check("t3_phase", 0, 32'(po2), 32'd1);
    check("t3_rise", 0, 32'(rs2), 32'd1);
    check("t3_wrap", 0, 32'(wr2), 32'd0);
    sync_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t3_hold", 0, 32'(po2), 32'd1);
    end
    cycle();
    check("t3_next", 0, 32'(po2), 32'd2);

    // 4: illegal ring values, all ones then all zeros
    div = 8'd1;
    for (int k = 0; k < 3; k++) cycle();
    cycle_forced(2'b11, 4'b1010);
    check("t4_phase", 0, 32'(po2), 32'd1);
    check("t4_err", 0, 32'(er2), 32'd1);
    check("t4_rise", 0, 32'(rs2), 32'd1);
    for (int k = 0; k < 4; k++) cycle();
    cycle_forced(2'b00, 4'b0000);
    check("t4z_phase", 0, 32'(po2), 32'd1);
    check("t4z_err", 0, 32'(er2), 32'd1);
    for (int k = 0; k < 4; k++) cycle();

    // 5: en low wins over sync_start, then restart
    en = 1'b0; sync_start = 1'b1; cycle();
    check("t5_phase", 0, 32'(po2), 32'd0);
    check("t5_rise", 0, 32'(rs2), 32'd0);
    check("t5_wrap", 0, 32'(wr2), 32'd0);
    en = 1'b1; sync_start = 1'b0; cycle();
    check("t5_restart", 0, 32'(po2), 32'd1);
    check("t5_restart_rise", 0, 32'(rs2), 32'd1);

    // 6: asynchronous reset mid-run, release with en high
    for (int k = 0; k < 3; k++) cycle();
    async_reset();
    cycle();
    check("t6_phase", 0, 32'(po2), 32'd1);

    // Randomized run
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 199);
      if (r < 2) begin
        async_reset();
      end else if (r < 12) begin
        do f4 = 4'($urandom_range(0, 15)); while ($countones(f4) == 1);
        cycle_forced(($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, f4);
      end else begin
        cycle();
      end
      en = ($urandom_range(0, 15) != 0);
      sync_start = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 7) == 0) div = DIV_W'($urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
